// File: rtl/book_snapshot_tx_if.sv
// Snapshot stream bus: 32-bit words with valid/ready handshake and
// start/end-of-packet markers. The master drives the word, the slave
// drives ready.
interface book_snapshot_tx_if;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_sop;
  logic        tx_eop;

  modport master (
    output tx_data,
    output tx_valid,
    output tx_sop,
    output tx_eop,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  tx_sop,
    input  tx_eop,
    output tx_ready
  );
endinterface

// File: rtl/book_snapshot_tx.sv
// Order book snapshot transmitter.
// On request, latches both sides of the book into a shadow register and
// streams it as one packet: a header word, then three words per level
// (all bid levels, then all ask levels). A request arriving while a
// packet is in flight is held one deep. Further requests are counted
// as overruns.
// Optional feature macro SNAP_CHECKSUM_EN: appends one XOR checksum word
// after the body, and moves eop onto that word.
module book_snapshot_tx #(
  parameter int          MAX_CONTRACTS = 10,
  parameter logic [15:0] MAGIC         = 16'hB00C
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [88*MAX_CONTRACTS-1:0] bid_levels,
  input  logic [88*MAX_CONTRACTS-1:0] ask_levels,
  input  logic                       snap_req,
  book_snapshot_tx_if.master         tx,
  output logic                       busy,
  output logic [7:0]                 seq,
  output logic [7:0]                 overrun_cnt
);

  localparam int         BOOK_W   = 176 * MAX_CONTRACTS;
  localparam logic [4:0] LAST_LVL = 5'(2 * MAX_CONTRACTS - 1);
  localparam logic [7:0] LEVELS_B = 8'(MAX_CONTRACTS);

`ifdef SNAP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, HDR, BODY, CKSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
`endif

  state_t              state;
  state_t              state_nxt;
  logic                pending;
  logic [BOOK_W-1:0]   shadow;
  logic [4:0]          lvl;
  logic [1:0]          ph;
  logic [87:0]         cur_lvl;
  logic [31:0]         body_word;
  logic                last_word;
  logic                start;
  logic                accept;
  logic [31:0]         data_c;
  logic                valid_c;
  logic                sop_c;
  logic                eop_c;
`ifdef SNAP_CHECKSUM_EN
  logic [31:0]         cksum;
`endif

  // Shadow layout: bid levels occupy the low slots, ask levels sit above
  // them, so the running level index 0..2N-1 addresses both sides directly.
  assign start     = (state == IDLE) && (snap_req || pending);
  assign accept    = valid_c && tx.tx_ready;
  assign cur_lvl   = shadow[88*int'(lvl) +: 88];
  assign last_word = (lvl == LAST_LVL) && (ph == 2'd2);
  assign busy      = (state != IDLE);

  assign tx.tx_data  = data_c;
  assign tx.tx_valid = valid_c;
  assign tx.tx_sop   = sop_c;
  assign tx.tx_eop   = eop_c;

  // Select the body word for the current level and phase (qty/orders, price hi, price lo).
  always_comb begin
    case (ph)
      2'd0:    body_word = {cur_lvl[87:64], 8'h00};
      2'd1:    body_word = cur_lvl[63:32];
      default: body_word = cur_lvl[31:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and stream outputs. Outputs depend only on registered state,
  // so they stay stable while a word waits for acceptance.
  always_comb begin
    state_nxt = state;
    valid_c   = 1'b0;
    data_c    = 32'h0;
    sop_c     = 1'b0;
    eop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (snap_req || pending) state_nxt = HDR;
      end
      HDR: begin
        valid_c = 1'b1;
        sop_c   = 1'b1;
        data_c  = {MAGIC, seq, LEVELS_B};
        if (tx.tx_ready) state_nxt = BODY;
      end
      BODY: begin
        valid_c = 1'b1;
        data_c  = body_word;
`ifdef SNAP_CHECKSUM_EN
        if (last_word && tx.tx_ready) state_nxt = CKSUM;
`else
        eop_c = last_word;
        if (last_word && tx.tx_ready) state_nxt = IDLE;
`endif
      end
`ifdef SNAP_CHECKSUM_EN
      CKSUM: begin
        valid_c = 1'b1;
        data_c  = cksum;
        eop_c   = 1'b1;
        if (tx.tx_ready) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Request bookkeeping (pending, seq, overruns) and body word position.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 1'b0;
      seq         <= 8'hFF;
      overrun_cnt <= 8'h00;
      lvl         <= 5'd0;
      ph          <= 2'd0;
    end else begin
      if (start) begin
        seq     <= seq + 8'd1;
        pending <= 1'b0;
      end else if ((state != IDLE) && snap_req) begin
        if (!pending)                    pending     <= 1'b1;
        else if (overrun_cnt != 8'hFF)   overrun_cnt <= overrun_cnt + 8'd1;
      end
      if (state != BODY) begin
        lvl <= 5'd0;
        ph  <= 2'd0;
      end else if (accept) begin
        if (ph == 2'd2) begin
          ph  <= 2'd0;
          lvl <= lvl + 5'd1;
        end else begin
          ph <= ph + 2'd1;
        end
      end
    end
  end

  // Atomic book capture; loads only when a packet starts.
  always_ff @(posedge clk) begin
    if (start) shadow <= {ask_levels, bid_levels};
  end

`ifdef SNAP_CHECKSUM_EN
  // Running XOR of every accepted header/body word of the current packet.
  always_ff @(posedge clk) begin
    if (reset || (state == IDLE)) cksum <= 32'h0;
    else if (accept)              cksum <= cksum ^ data_c;
  end
`endif

endmodule

// File: tb/tb_book_snapshot_tx.sv
// Testbench for book_snapshot_tx: directed and randomized packets checked
// against a packet model built from the book contents.
module tb_book_snapshot_tx;
  localparam int N = 10;
`ifdef SNAP_CHECKSUM_EN
  localparam int PKT_LEN = 2 + 6*N;
  localparam logic [31:0] ZERO_LAST = 32'hB00C_000A;
`else
  localparam int PKT_LEN = 1 + 6*N;
  localparam logic [31:0] ZERO_LAST = 32'h0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [88*N-1:0] bid_levels;
  logic [88*N-1:0] ask_levels;
  logic            snap_req;
  logic            busy;
  logic [7:0]      seq;
  logic [7:0]      overrun_cnt;

  book_snapshot_tx_if bus();

  book_snapshot_tx #(.MAX_CONTRACTS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .bid_levels  (bid_levels),
    .ask_levels  (ask_levels),
    .snap_req    (snap_req),
    .tx          (bus.master),
    .busy        (busy),
    .seq         (seq),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  // Book model: side 0 = bid, side 1 = ask.
  logic [15:0] m_qty   [2][N];
  logic [7:0]  m_ord   [2][N];
  logic [63:0] m_price [2][N];

  logic [31:0] exp_data[$];
  bit          exp_sop[$];
  bit          exp_eop[$];
  logic [7:0]  exp_seq;
  int          exp_ovr;

  logic [31:0] got_data[$];
  bit          got_sop[$];
  bit          got_eop[$];
  int          got_cyc[$];
  int          cyc = 0;
  int          eop_cnt = 0;
  int          stall_err = 0;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  logic        pv = 1'b0, pr = 1'b0, ps = 1'b0, pe = 1'b0, prst = 1'b1;
  logic [31:0] pd = 32'h0;

  // Monitor: records accepted words and checks hold-while-stalled.
  always @(negedge clk) begin
    cyc++;
    if (!prst && !reset && pv && !pr) begin
      if (!(bus.tx_valid === 1'b1 && bus.tx_data === pd &&
            bus.tx_sop === ps && bus.tx_eop === pe))
        stall_err++;
    end
    if (!reset && bus.tx_valid && bus.tx_ready) begin
      got_data.push_back(bus.tx_data);
      got_sop.push_back(bus.tx_sop);
      got_eop.push_back(bus.tx_eop);
      got_cyc.push_back(cyc);
      if (bus.tx_eop) eop_cnt++;
    end
    pv = bus.tx_valid; pr = bus.tx_ready; pd = bus.tx_data;
    ps = bus.tx_sop;   pe = bus.tx_eop;   prst = reset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       bus.tx_ready = 1'b1;
      1:       bus.tx_ready = ~bus.tx_ready;
      default: bus.tx_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic set_book();
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < N; l++) begin
        if (s == 0) bid_levels[88*l +: 88] = {m_qty[s][l], m_ord[s][l], m_price[s][l]};
        else        ask_levels[88*l +: 88] = {m_qty[s][l], m_ord[s][l], m_price[s][l]};
      end
  endtask

  task automatic zero_book();
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < N; l++) begin
        m_qty[s][l] = '0; m_ord[s][l] = '0; m_price[s][l] = '0;
      end
    set_book();
  endtask

  task automatic rand_book();
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < N; l++) begin
        m_qty[s][l]   = 16'($urandom);
        m_ord[s][l]   = 8'($urandom);
        m_price[s][l] = {32'($urandom), 32'($urandom)};
      end
    set_book();
  endtask

  function automatic void push_word(input logic [31:0] w, input bit s);
    exp_data.push_back(w);
    exp_sop.push_back(s);
    exp_eop.push_back(1'b0);
  endfunction

  // Expected packet for the current book model with the next sequence number.
  function automatic void expect_pkt();
    logic [31:0] x;
    logic [31:0] w;
    exp_seq = exp_seq + 8'd1;
    w = {16'hB00C, exp_seq, 8'(N)};
    push_word(w, 1'b1);
    x = w;
    for (int s = 0; s < 2; s++)
      for (int l = 0; l < N; l++) begin
        w = {m_qty[s][l], m_ord[s][l], 8'h00};  push_word(w, 1'b0); x = x ^ w;
        w = m_price[s][l][63:32];               push_word(w, 1'b0); x = x ^ w;
        w = m_price[s][l][31:0];                push_word(w, 1'b0); x = x ^ w;
      end
`ifdef SNAP_CHECKSUM_EN
    push_word(x, 1'b0);
`endif
    exp_eop[exp_eop.size()-1] = 1'b1;
  endfunction

  task automatic clear_mon();
    got_data.delete(); got_sop.delete(); got_eop.delete(); got_cyc.delete();
    exp_data.delete(); exp_sop.delete(); exp_eop.delete();
    eop_cnt = 0;
    stall_err = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    snap_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_seq = 8'hFF;
    exp_ovr = 0;
  endtask

  task automatic pulse_req();
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
  endtask

  task automatic wait_eops(input int n);
    for (int k = 0; k < 4000 && eop_cnt < n; k++) step();
    chk("eop_timeout", 32'(eop_cnt >= n), 32'd1);
  endtask

  task automatic wait_words(input int n);
    for (int k = 0; k < 4000 && got_data.size() < n; k++) step();
    chk("word_timeout", 32'(got_data.size() >= n), 32'd1);
  endtask

  task automatic compare_pkts(input string tag);
    int n;
    chk({tag, "_len"}, 32'(got_data.size()), 32'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
      chk($sformatf("%s_sop%0d", tag, i), 32'(got_sop[i]), 32'(exp_sop[i]));
      chk($sformatf("%s_eop%0d", tag, i), 32'(got_eop[i]), 32'(exp_eop[i]));
    end
    chk({tag, "_stall"}, 32'(stall_err), 32'd0);
  endtask

  initial begin
    snap_req     = 1'b0;
    bus.tx_ready = 1'b1;
    bid_levels   = '0;
    ask_levels   = '0;
    exp_seq      = 8'hFF;
    exp_ovr      = 0;
    zero_book();

    // Reset state
    do_reset();
    chk("rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_data", bus.tx_data, 32'h0);
    chk("rst_sop", 32'(bus.tx_sop), 32'd0);
    chk("rst_eop", 32'(bus.tx_eop), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_seq", 32'(seq), 32'hFF);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);

    // Basic packet, ready held high
    m_qty[0][0] = 16'd8; m_ord[0][0] = 8'd8; m_price[0][0] = 64'd11;
    set_book();
    clear_mon();
    expect_pkt();
    snap_req = 1'b1;
    chk("lat_before", 32'(bus.tx_valid), 32'd0);
    step();
    snap_req = 1'b0;
    chk("lat_after", 32'(bus.tx_valid), 32'd1);
    wait_eops(1);
    compare_pkts("basic");
    if (got_data.size() == PKT_LEN) begin
      chk("basic_w0", got_data[0], 32'hB00C_000A);
      chk("basic_w1", got_data[1], 32'h0008_0800);
      chk("basic_w2", got_data[2], 32'h0);
      chk("basic_w3", got_data[3], 32'h0000_000B);
      chk("basic_eop_last", 32'(got_eop[PKT_LEN-1]), 32'd1);
      chk("basic_nobubble", 32'(got_cyc[PKT_LEN-1] - got_cyc[0]), 32'(PKT_LEN-1));
    end
    chk("basic_seq", 32'(seq), 32'd0);

    // Same packet with ready toggling
    do_reset();
    ready_mode = 1;
    clear_mon();
    expect_pkt();
    pulse_req();
    wait_eops(1);
    compare_pkts("toggle");
    ready_mode = 0;
    bus.tx_ready = 1'b1;

    // Three requests during one packet: one pending, two overruns
    do_reset();
    clear_mon();
    expect_pkt();
    expect_pkt();
    pulse_req();
    step();
    pulse_req();
    step();
    pulse_req();
    step();
    pulse_req();
    wait_eops(2);
    compare_pkts("coalesce");
    chk("coalesce_ovr", 32'(overrun_cnt), 32'd2);
    chk("coalesce_seq", 32'(seq), 32'd1);
    if (got_data.size() == 2*PKT_LEN)
      chk("coalesce_gap", 32'(got_cyc[PKT_LEN] - got_cyc[PKT_LEN-1]), 32'd2);
    for (int k = 0; k < 20; k++) step();
    chk("coalesce_nomore", 32'(eop_cnt), 32'd2);
    chk("coalesce_idle", 32'(busy), 32'd0);

    // Book change mid-packet does not affect it
    do_reset();
    clear_mon();
    expect_pkt();
    pulse_req();
    wait_words(10);
    m_price[0][0] = 64'd12;
    set_book();
    expect_pkt();
    pulse_req();
    wait_eops(2);
    compare_pkts("atomic");
    if (got_data.size() == 2*PKT_LEN) begin
      chk("atomic_old", got_data[3], 32'h0000_000B);
      chk("atomic_new", got_data[PKT_LEN+3], 32'h0000_000C);
    end

    // Reset mid-packet with a request pending
    do_reset();
    clear_mon();
    pulse_req();
    wait_words(30);
    pulse_req();
    reset = 1'b1;
    step();
    chk("midrst_valid", 32'(bus.tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_seq", 32'(seq), 32'hFF);
    chk("midrst_ovr", 32'(overrun_cnt), 32'd0);
    reset = 1'b0;
    step();
    step();
    step();
    chk("midrst_nopend", 32'(bus.tx_valid), 32'd0);
    chk("midrst_noeop", 32'(eop_cnt), 32'd0);
    exp_seq = 8'hFF;
    clear_mon();
    expect_pkt();
    pulse_req();
    wait_eops(1);
    compare_pkts("afterrst");

    // Randomized books, random ready, random extra requests
    for (int it = 0; it < 6; it++) begin
      int extra;
      rand_book();
      ready_mode = 2;
      clear_mon();
      extra = $urandom_range(0, 3);
      expect_pkt();
      if (extra > 0) expect_pkt();
      if (extra > 1) exp_ovr += extra - 1;
      pulse_req();
      for (int e = 0; e < extra; e++) begin
        step();
        pulse_req();
      end
      wait_eops((extra > 0) ? 2 : 1);
      compare_pkts($sformatf("rand%0d", it));
      chk($sformatf("rand%0d_ovr", it), 32'(overrun_cnt), 32'(exp_ovr));
      chk($sformatf("rand%0d_seq", it), 32'(seq), 32'(exp_seq));
      for (int k = 0; k < 4; k++) step();
    end
    ready_mode = 0;
    bus.tx_ready = 1'b1;

    // All-zero book: last word is the checksum (header) or a zero price word
    zero_book();
    do_reset();
    clear_mon();
    expect_pkt();
    pulse_req();
    wait_eops(1);
    compare_pkts("zero");
    if (got_data.size() == PKT_LEN) begin
      chk("zero_last", got_data[PKT_LEN-1], ZERO_LAST);
      chk("zero_last_eop", 32'(got_eop[PKT_LEN-1]), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/book_snapshot_tx.md
Name: book_snapshot_tx

Overview:
- Reader side of the order book: on request, captures a full copy of both sides of the book (MAX_CONTRACTS bid levels and MAX_CONTRACTS ask levels, 88 bits each) and serializes it as a 32-bit word packet.
- Output is a valid/ready stream with start/end-of-packet markers, feeding the host bridge or debug FIFO.
- The capture is atomic, so book updates during transmission never corrupt a packet.

Parameters:
- MAX_CONTRACTS, 10, levels per side; supported range 1..15.
- MAGIC, 16'hB00C, constant in the header upper half.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- bid_levels  in  88*MAX_CONTRACTS  level i at [88*i+87 -: 88]; per level {QUANTITY[15:0], NUM_ORDERS[7:0], PRICE[63:0]}; level 0 = best bid
- ask_levels  in  88*MAX_CONTRACTS  same layout; level 0 = best (lowest) ask
- snap_req  in  1  single-cycle snapshot request, e.g. tied to orderbook_ready
- tx_data  out  32  stream word
- tx_valid  out  1  word valid
- tx_ready  in  1  sink accepts the word when tx_valid && tx_ready
- tx_sop  out  1  high with the header word
- tx_eop  out  1  high with the last word of the packet
- busy  out  1  high whenever the FSM is not IDLE
- seq  out  8  sequence number of the most recently started packet
- overrun_cnt  out  8  saturating count of coalesced or lost requests

Behaviour:
- Reset values:
  - tx_data = 0, tx_valid = 0, tx_sop = 0, tx_eop = 0, busy = 0
  - seq = 8'hFF, so the first packet is seq 0
  - overrun_cnt = 0, pending = 0
  - FSM = IDLE
- FSM states: IDLE, HDR, BODY (plus CKSUM, see Optional Feature).
- IDLE:
  - On snap_req or pending: capture bid_levels/ask_levels into the shadow register and increment seq (mod 256).
  - Clear pending and go to HDR.
  - tx_valid rises the cycle after the request (1-cycle latency).
- HDR:
  - tx_data = {MAGIC, seq_new, 8'(MAX_CONTRACTS)}, tx_sop = 1.
  - Advance to BODY on acceptance.
- BODY:
  - Emits 3 words per level: all bid levels 0..N-1, then all ask levels 0..N-1.
  - Per level: w0 = {QUANTITY, NUM_ORDERS, 8'h00}, w1 = PRICE[63:32], w2 = PRICE[31:0].
  - Word counter runs 0..6N-1.
  - The last word carries tx_eop = 1; on its acceptance go to IDLE.
- Packet length: 1 + 6*MAX_CONTRACTS words (61 at the default).
- Handshake rules:
  - Once tx_valid is asserted, tx_valid, tx_data, tx_sop and tx_eop hold stable until accepted.
  - tx_valid never drops without acceptance, except on reset.
  - Back-to-back words are sent with no bubbles while tx_ready = 1.
- Requests while busy:
  - snap_req sets pending; pending is one deep.
  - A snap_req while pending is already set increments overrun_cnt, saturating at 255.
  - The pending request is captured on the IDLE cycle after eop acceptance. The gap between packets is one idle cycle; tx_valid is low there.
- Simultaneous events: snap_req in the same cycle as eop acceptance is treated as busy and becomes pending.
- Shadow register only loads in IDLE; input changes during HDR/BODY do not affect the packet.
- Reset mid-packet: the next cycle shows tx_valid = 0, the FSM is IDLE, pending is cleared, and seq and overrun_cnt return to reset values. The partial packet is abandoned with no eop.
- tx_ready held low indefinitely: the block stalls with no data loss; new requests follow the pending/overrun rules.

Optional Feature:
- Macro: SNAP_CHECKSUM_EN.
- Defined:
  - CKSUM state follows BODY and appends one word equal to the XOR of the header and all body words.
  - tx_eop moves from the last body word to this checksum word.
  - Packet length is 2 + 6*MAX_CONTRACTS (62 at the default).
- Undefined: no CKSUM state; eop is on the last body word and the length is 61.

Test Plan:
- Book level 0 = {qty 8, orders 8, price 11} and reset release; single snap_req, tx_ready = 1 -> 61 consecutive words:
  - word0 = 32'hB00C_000A with sop
  - word1 = 32'h0008_0800, word2 = 0, word3 = 32'h0000_000B
  - eop on word 60
- Same packet with tx_ready toggled in a 1-0-1-0 pattern -> identical word sequence; data stable during every stall cycle.
- Three snap_req pulses during one packet -> exactly two packets total (seq 0 then 1), overrun_cnt = 2, one idle cycle between eop and the next sop.
- Change bid_levels price 11 -> 12 at word 10 of a packet -> current packet still shows 11; the next packet shows 12.
- Assert reset at word 30 -> next cycle tx_valid = 0, busy = 0, seq = 8'hFF; a subsequent snap_req yields a full packet with seq 0.
- SNAP_CHECKSUM_EN defined, all levels zero -> 62 words, last word = 32'hB00C_000A XOR 0 = 32'hB00C_000A, with eop.
